adder_op_sequencer: RTL and testbench
=====================================

# adder_op_sequencer

Sequencing controller for the board-level 4-bit switch adder. It walks the user through operand entry with a debounced push-button:
- capture A from SW[3:0];
- capture B from SW[7:4] and carry-in from SW[8];
- register the sum;
- hold it on LEDR and two active-low seven-segment digits.

It sits between the DE2 switches/keys and the display outputs. It replaces the free-running combinational adder path with a stepped, registered one.

## Interface
- `W`, 4, operand width in bits; result is W+1 bits.
- `DEBOUNCE_CYCLES`, 500000, stable-sample count for the key (10 ms at 50 MHz); minimum 2.
- `CLOCK_50` input 1: system clock; all logic is rising-edge.
- `RST_N` input 1: asynchronous, active-low reset; one clock domain only.
- `SW` input 18: slide switches. [3:0] operand A, [7:4] operand B, [8] carry-in, [17] chain mode; others ignored.
- `KEY_NEXT` input 1: push-button, active-low, asynchronous to CLOCK_50.
- `LEDR` output 18: [3:0] reg_a, [7:4] reg_b, [8] reg_cin, [13:9] result, [17:14] zero.
- `LEDG` output 9: [3:0] one-hot state, [7] overflow (result[4] while in SHOW), others zero.
- `HEX0` output 7: ones digit, active-low segments.
- `HEX1` output 7: tens digit, active-low segments.

## Operation
**Key path**
- KEY_NEXT passes through a 2-flop synchronizer, then the debouncer.
- The debouncer emits `press`, a single-cycle pulse, once the synchronized key has been low for DEBOUNCE_CYCLES consecutive clocks.
- After a press, the key must be stably high for DEBOUNCE_CYCLES before another press is accepted. Holding the key produces exactly one pulse.

**FSM states:** LOAD_A (LEDG 0001), LOAD_B (0010), CALC (0100), SHOW (1000).
- LOAD_A + press: reg_a <= SW[3:0]; go to LOAD_B.
- LOAD_B + press: reg_b <= SW[7:4], reg_cin <= SW[8]; go to CALC.
- CALC: result <= reg_a + reg_b + reg_cin, 5-bit, never truncated, maximum 31; go to SHOW unconditionally. A press in CALC is dropped.
- SHOW + press with SW[17]=0: clear reg_a, reg_b, reg_cin and result; go to LOAD_A.
- SHOW + press with SW[17]=1 (chain): reg_a <= result[3:0], reg_b/reg_cin cleared, result kept; go to LOAD_B.
- No press: hold state.

**Display source**
- LOAD_A: live SW[3:0].
- LOAD_B: live SW[7:4].
- CALC and SHOW: result.
- The source value (0..31) is split into tens digit (0..3) and ones digit (0..9) by compare-subtract against 30/20/10.
- Segment codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.

**Reset** (asynchronous assert, synchronous release):
- state LOAD_A;
- all data registers 0;
- LEDR 0; LEDG 000000001;
- HEX0 and HEX1 1000000;
- debouncer counter 0, key considered released.

A reset mid-operation aborts with no partial update.

## Timing
- All outputs are registered. HEX, LEDR and LEDG reflect state/registers one clock later.
- Key-to-press latency: 2 sync cycles + DEBOUNCE_CYCLES.
- Press in cycle n, state LOAD_B: CALC in n+1; result registered at the end of n+1; SHOW from n+2.
- Result appears on LEDR[13:9] and HEX from n+3; LEDG[7] is valid in the same cycle.
- Live switch display lag: 2 clocks (switches are not synchronized beyond the output register; this is a display-only path).

## Configuration
- `ADDER_SEQ_DEBOUNCE_EN` defined: the full debounce counter described above, with width $clog2(DEBOUNCE_CYCLES+1).
- Not defined: `press` is the falling edge of the synchronized key (one pulse per edge, no counter). DEBOUNCE_CYCLES is then unused.

## Structure
- Package `adder_seq_pkg`:
  - state enum (LOAD_A, LOAD_B, CALC, SHOW);
  - SEG7 digit constants 0..9;
  - SEG7_BLANK = 1111111;
  - seg7 encode function.
- Sub-module `key_debounce`: synchronizer plus debounce/edge logic producing `press`; the macro is confined to it.
- The top level holds the FSM, operand/result registers, BCD split and output registers.

## Test plan
Run with DEBOUNCE_CYCLES=4.
1. Reset, then SW=0x1F5 (A=5, B=F, cin=1), three clean presses → LEDR[13:9]=21 (10101), HEX1=0100100, HEX0=1111001, LEDG[7]=1 (result 21 ≥ 16), LEDG=0x088.
2. Chain: after test 1, SW[17]=1, press → LEDG[1]=1 and LEDR[3:0]=5. Then B=3, cin=0, press → result 8, HEX0=0000000, HEX1=1000000.
3. Bounce: the key toggles every 2 cycles for 20 cycles, then is held low 10 cycles → exactly one press; state advances by one.
4. Long hold: the key is held low for 100 cycles → one press only. Release and press again → second advance.
5. Reset during CALC/SHOW: assert RST_N low mid-cycle → the same cycle shows LEDG=0x001, LEDR=0, HEX0/HEX1=1000000.
6. Max/min: A=F, B=F, cin=1 → result 31, HEX1=0110000, HEX0=1111001. A=0, B=0, cin=0 → 0 with LEDG[7]=0.

Source files
------------

// File: rtl/adder_op_sequencer_pkg.sv
// Shared types and constants for the stepped switch adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adder_seq_pkg;

    // One-hot encoding so the state can drive LEDG[3:0] directly
    typedef enum logic [3:0] {
        LOAD_A = 4'b0001,
        LOAD_B = 4'b0010,
        CALC   = 4'b0100,
        SHOW   = 4'b1000
    } state_t;

    // Active-low seven-segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG7_0     = 7'b1000000;
    localparam logic [6:0] SEG7_1     = 7'b1111001;
    localparam logic [6:0] SEG7_2     = 7'b0100100;
    localparam logic [6:0] SEG7_3     = 7'b0110000;
    localparam logic [6:0] SEG7_4     = 7'b0011001;
    localparam logic [6:0] SEG7_5     = 7'b0010010;
    localparam logic [6:0] SEG7_6     = 7'b0000010;
    localparam logic [6:0] SEG7_7     = 7'b1111000;
    localparam logic [6:0] SEG7_8     = 7'b0000000;
    localparam logic [6:0] SEG7_9     = 7'b0010000;
    localparam logic [6:0] SEG7_BLANK = 7'b1111111;

    // Decimal digit to segment pattern; anything above 9 blanks the digit
    function automatic logic [6:0] seg7_encode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG7_0;
            4'd1:    seg = SEG7_1;
            4'd2:    seg = SEG7_2;
            4'd3:    seg = SEG7_3;
            4'd4:    seg = SEG7_4;
            4'd5:    seg = SEG7_5;
            4'd6:    seg = SEG7_6;
            4'd7:    seg = SEG7_7;
            4'd8:    seg = SEG7_8;
            4'd9:    seg = SEG7_9;
            default: seg = SEG7_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/adder_op_sequencer_if.sv
// Board-side bundle: slide switches and key in, LEDs and two HEX digits out.
// Latency: n/a (wiring only).
// Backpressure: none; the key is a human-paced pulse source.
interface adder_op_sequencer_if;
    logic [17:0] SW;
    logic        KEY_NEXT;
    logic [17:0] LEDR;
    logic [8:0]  LEDG;
    logic [6:0]  HEX0;
    logic [6:0]  HEX1;

    // Board / stimulus side
    modport master (
        output SW,
        output KEY_NEXT,
        input  LEDR,
        input  LEDG,
        input  HEX0,
        input  HEX1
    );

    // Sequencer side
    modport slave (
        input  SW,
        input  KEY_NEXT,
        output LEDR,
        output LEDG,
        output HEX0,
        output HEX1
    );
endinterface

// File: rtl/adder_op_sequencer_key_debounce.sv
// Push-button conditioner: 2-flop synchronizer then debounce (or plain edge detect).
// Latency: 2 sync cycles + DEBOUNCE_CYCLES (debounced) or 2 sync cycles + 1 (edge only).
// Backpressure: none; press is a one-cycle pulse. Build macro: ADDER_SEQ_DEBOUNCE_EN.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    logic sync_1;
    logic key_sync;

    // Out-of-range settings show up as this named scope in the elaborated hierarchy
    if (DEBOUNCE_CYCLES < 2) begin : g_debounce_cycles_below_min
    end

    // Two-flop synchronizer; resets to the released (high) level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1   <= 1'b1;
            key_sync <= 1'b1;
        end else begin
            sync_1   <= key_n;
            key_sync <= sync_1;
        end
    end

`ifdef ADDER_SEQ_DEBOUNCE_EN
    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          held;

    // Count consecutive samples that disagree with the accepted level; with an
    // active-low key, "disagree" is key_sync == held. Flip after a full run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            held  <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (key_sync == held) begin
                if (cnt == CNT_LAST) begin
                    cnt   <= '0;
                    held  <= ~held;
                    press <= ~held;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
`else
    logic key_prev;

    // One pulse per falling edge of the synchronized key
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_prev <= 1'b1;
            press    <= 1'b0;
        end else begin
            key_prev <= key_sync;
            press    <= key_prev & ~key_sync;
        end
    end
`endif

endmodule

// File: rtl/adder_op_sequencer.sv
// Stepped 4-bit switch adder: key presses walk A -> B/cin -> sum -> display.
// Latency: result on LEDR/HEX 3 clocks after the B press; live switch echo lags 2 clocks.
// Backpressure: presses arriving in CALC are dropped. Build macro: ADDER_SEQ_DEBOUNCE_EN (key path).
module adder_op_sequencer
    import adder_seq_pkg::*;
#(
    parameter int W               = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                 CLOCK_50,
    input  logic                 RST_N,
    adder_op_sequencer_if.slave  io
);

    localparam int RW = W + 1;

    logic [1:0]    rst_pipe;
    logic          rst_n;
    logic          press;
    state_t        state;
    logic [W-1:0]  reg_a;
    logic [W-1:0]  reg_b;
    logic          reg_cin;
    logic [RW-1:0] result;
    logic [7:0]    sw_q;
    logic [RW-1:0] disp_val;
    logic [1:0]    tens;
    logic [3:0]    ones;
    logic [17:0]   ledr_q;
    logic [8:0]    ledg_q;
    logic [6:0]    hex0_q;
    logic [6:0]    hex1_q;
    logic          sw_unused_bits;

    assign sw_unused_bits = ^io.SW[16:9];

    // Reset asserts immediately, releases on a clock edge
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            rst_pipe <= 2'b00;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign rst_n = rst_pipe[1];

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key (
        .clk   (CLOCK_50),
        .rst_n (rst_n),
        .key_n (io.KEY_NEXT),
        .press (press)
    );

    // Operand-entry FSM with its operand and result registers
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state   <= LOAD_A;
            reg_a   <= '0;
            reg_b   <= '0;
            reg_cin <= 1'b0;
            result  <= '0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (press) begin
                        reg_a <= io.SW[W-1:0];
                        state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (press) begin
                        reg_b   <= io.SW[W+3:4];
                        reg_cin <= io.SW[8];
                        state   <= CALC;
                    end
                end
                CALC: begin
                    result <= RW'(reg_a) + RW'(reg_b) + RW'(reg_cin);
                    state  <= SHOW;
                end
                SHOW: begin
                    if (press) begin
                        reg_b   <= '0;
                        reg_cin <= 1'b0;
                        if (io.SW[17]) begin
                            reg_a <= result[W-1:0];
                            state <= LOAD_B;
                        end else begin
                            reg_a  <= '0;
                            result <= '0;
                            state  <= LOAD_A;
                        end
                    end
                end
                default: state <= LOAD_A;
            endcase
        end
    end

    // Display-only copy of the operand switches; not a synchronizer
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            sw_q <= '0;
        end else begin
            sw_q <= io.SW[7:0];
        end
    end

    // Pick what the HEX digits show and split it into tens/ones
    always_comb begin
        case (state)
            LOAD_A:  disp_val = RW'(sw_q[3:0]);
            LOAD_B:  disp_val = RW'(sw_q[7:4]);
            default: disp_val = result;
        endcase
        tens = 2'd0;
        ones = disp_val[3:0];
        if (disp_val >= RW'(30)) begin
            tens = 2'd3;
            ones = 4'(disp_val - RW'(30));
        end else if (disp_val >= RW'(20)) begin
            tens = 2'd2;
            ones = 4'(disp_val - RW'(20));
        end else if (disp_val >= RW'(10)) begin
            tens = 2'd1;
            ones = 4'(disp_val - RW'(10));
        end
    end

    // Registered board outputs
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            ledr_q <= '0;
            ledg_q <= {5'b00000, LOAD_A};
            hex0_q <= SEG7_0;
            hex1_q <= SEG7_0;
        end else begin
            ledr_q <= {4'b0000, result, reg_cin, reg_b, reg_a};
            ledg_q <= {1'b0, (state == SHOW) & result[W], 3'b000, state};
            hex0_q <= seg7_encode(ones);
            hex1_q <= seg7_encode({2'b00, tens});
        end
    end

    assign io.LEDR = ledr_q;
    assign io.LEDG = ledg_q;
    assign io.HEX0 = hex0_q;
    assign io.HEX1 = hex1_q;

endmodule

// File: tb/tb_adder_op_sequencer.sv
// Scoreboard bench for adder_op_sequencer with DEBOUNCE_CYCLES=4.
// Latency: n/a.
// Backpressure: n/a.
module tb_adder_op_sequencer;

    localparam int DC = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    adder_op_sequencer_if io ();

    adder_op_sequencer #(
        .W               (4),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .CLOCK_50 (clk),
        .RST_N    (rst_n),
        .io       (io)
    );

    typedef struct {
        logic [17:0] ledr;
        logic [8:0]  ledg;
        logic [6:0]  hex1;
        logic [6:0]  hex0;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [6:0]  seg_tbl [0:9];
    logic [17:0] sw;
    logic [3:0]  m_a;
    logic [3:0]  m_b;
    logic        m_cin;
    logic [4:0]  m_res;
    logic [3:0]  m_state;
    logic        show_prev = 1'b0;
    bit          found;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t make_exp();
        exp_t e;
        int   r;
        r      = int'(m_a) + int'(m_b) + int'(m_cin);
        e.ledr = {4'b0000, 5'(r), m_cin, m_b, m_a};
        e.ledg = {1'b0, r >= 16, 3'b000, 4'b1000};
        e.hex1 = seg_tbl[r / 10];
        e.hex0 = seg_tbl[r % 10];
        return e;
    endfunction

    task automatic set_sw(input logic [17:0] v);
        sw    = v;
        io.SW = v;
    endtask

    task automatic model_reset();
        m_a     = 4'd0;
        m_b     = 4'd0;
        m_cin   = 1'b0;
        m_res   = 5'd0;
        m_state = 4'b0001;
    endtask

    // Expected effect of one accepted press given the current switches
    task automatic model_press(input bit push_en);
        case (m_state)
            4'b0001: begin
                m_a     = sw[3:0];
                m_state = 4'b0010;
            end
            4'b0010: begin
                m_b     = sw[7:4];
                m_cin   = sw[8];
                m_res   = {1'b0, m_a} + {1'b0, m_b} + {4'b0000, m_cin};
                if (push_en) sb.push_back(make_exp());
                m_state = 4'b1000;
            end
            default: begin
                m_b   = 4'd0;
                m_cin = 1'b0;
                if (sw[17]) begin
                    m_a     = m_res[3:0];
                    m_state = 4'b0010;
                end else begin
                    m_a     = 4'd0;
                    m_res   = 5'd0;
                    m_state = 4'b0001;
                end
            end
        endcase
    endtask

    task automatic check_settled(input string tag);
        check({tag, "_state"}, 32'(io.LEDG[3:0]), 32'(m_state));
        check({tag, "_ledr"}, 32'(io.LEDR), 32'({4'b0000, m_res, m_cin, m_b, m_a}));
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_ledg"}, 32'(io.LEDG), 32'h001);
        check({tag, "_ledr"}, 32'(io.LEDR), 32'h0);
        check({tag, "_hex0"}, 32'(io.HEX0), 32'(7'b1000000));
        check({tag, "_hex1"}, 32'(io.HEX1), 32'(7'b1000000));
    endtask

    task automatic check_live(input string tag, input int v);
        check({tag, "_hex1"}, 32'(io.HEX1), 32'(seg_tbl[v / 10]));
        check({tag, "_hex0"}, 32'(io.HEX0), 32'(seg_tbl[v % 10]));
    endtask

    // Clean press: low for low_cycles, then released long enough to re-arm
    task automatic press_key(input string tag, input int low_cycles, input bit push_en);
        model_press(push_en);
        io.KEY_NEXT = 1'b0;
        repeat (low_cycles) @(negedge clk);
        io.KEY_NEXT = 1'b1;
        repeat (12) @(negedge clk);
        check_settled(tag);
    endtask

    // Scoreboard: compare on each entry into SHOW as seen on LEDG
    always @(negedge clk) begin
        exp_t e;
        if (io.LEDG[3] && !show_prev) begin
            if (sb.size() == 0) begin
                check("show_without_expect", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check("sb_ledr", 32'(io.LEDR), 32'(e.ledr));
                check("sb_ledg", 32'(io.LEDG), 32'(e.ledg));
                check("sb_hex1", 32'(io.HEX1), 32'(e.hex1));
                check("sb_hex0", 32'(io.HEX0), 32'(e.hex0));
            end
        end
        show_prev <= io.LEDG[3];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: sim time %0t exceeded, summary not reached", $time);
        $fatal(1, "watchdog timeout");
    end

    initial begin
        seg_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        set_sw(18'h0);
        io.KEY_NEXT = 1'b1;
        model_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outs("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 1: A=5, B=F, cin=1 -> 21
        set_sw(18'h001F5);
        repeat (3) @(negedge clk);
        check_live("live_a", 5);
        press_key("t1_a", 12, 1'b1);
        check_live("live_b", 15);
        press_key("t1_b", 12, 1'b1);
        check("t1_ledg", 32'(io.LEDG), 32'h088);

        // 2: chain result into A, then B=3, cin=0 -> 8
        set_sw(18'h20000);
        press_key("t2_chain", 12, 1'b1);
        check("t2_ledr_a", 32'(io.LEDR[3:0]), 32'd5);
        set_sw(18'h00030);
        press_key("t2_b", 12, 1'b1);

        // 3: bouncing key from SHOW back to LOAD_A
        set_sw(18'h00000);
`ifdef ADDER_SEQ_DEBOUNCE_EN
        model_press(1'b1);
        for (int i = 0; i < 10; i++) begin
            io.KEY_NEXT = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (2) @(negedge clk);
        end
        io.KEY_NEXT = 1'b0;
        repeat (10) @(negedge clk);
        io.KEY_NEXT = 1'b1;
        repeat (12) @(negedge clk);
        check_settled("t3_bounce");
`else
        press_key("t3_edge", 12, 1'b1);
`endif

        // 4: long hold gives one advance, a second press gives another
        set_sw(18'h00197);
        press_key("t4_hold", 100, 1'b1);
        press_key("t4_again", 12, 1'b1);

        // 5a: reset while showing
        rst_n = 1'b0;
        #1;
        check_reset_outs("t5_show");
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_settled("t5_post1");

        // 5b: reset right after the calculation step
        set_sw(18'h00022);
        press_key("t5_a", 12, 1'b1);
        model_press(1'b0);
        io.KEY_NEXT = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (io.LEDG[2]) found = 1'b1;
        end
        check("t5_calc_seen", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outs("t5_calc");
        io.KEY_NEXT = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check_settled("t5_post2");

        // 6: maximum then minimum
        set_sw(18'h001FF);
        press_key("t6_max_a", 12, 1'b1);
        press_key("t6_max_b", 12, 1'b1);
        check("t6_max_ledg", 32'(io.LEDG), 32'h088);
        set_sw(18'h00000);
        press_key("t6_clear", 12, 1'b1);
        press_key("t6_min_a", 12, 1'b1);
        press_key("t6_min_b", 12, 1'b1);
        check("t6_min_ledg", 32'(io.LEDG), 32'h008);

        repeat (5) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
